// File: rtl/mem_access_unit.sv
// Load/store unit between the memory stage and a word-organised data RAM.
// Define MEM_MISALIGN_SPLIT_EN to split word-straddling accesses into two RAM transactions.
module mem_access_unit #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  iClk,
    input  logic                  iRstN,
    input  logic                  iReqValid,
    output logic                  oReqReady,
    input  logic [3:0]            iMemControl,
    input  logic [ADDR_WIDTH-1:0] iAddr,
    input  logic [31:0]           iWriteData,
    output logic                  oBusy,
    output logic                  oRespValid,
    output logic [31:0]           oRespData,
    output logic                  oRespErr,
    output logic                  oRamReq,
    input  logic                  iRamAck,
    output logic                  oRamWe,
    output logic [3:0]            oRamBe,
    output logic [ADDR_WIDTH-3:0] oRamAddr,
    output logic [31:0]           oRamWData,
    input  logic [31:0]           iRamRData
);
    localparam int WA = ADDR_WIDTH - 2;

`ifdef MEM_MISALIGN_SPLIT_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACC1 = 2'd1, S_ACC2 = 2'd2, S_RESP = 2'd3} state_e;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACC1 = 2'd1, S_RESP = 2'd3} state_e;
`endif

    state_e        state_q, state_d;
    logic          st_q, sgn_q;
    logic [2:0]    size_q;
    logic [1:0]    off_q;
    logic [WA-1:0] waddr_q;
    logic [7:0]    be_q;
    logic [63:0]   wimg_q;
    logic [31:0]   rd0_q, rd1_q;
`ifdef MEM_MISALIGN_SPLIT_EN
    logic          strad_q;
`else
    logic          err_q;
`endif

    // Request decode; size 0 marks the "none" codes
    logic [2:0]  size;
    logic        sgn, st, strad, accept;
    logic [3:0]  smask;
    logic [7:0]  be_img;
    logic [63:0] w_img;

    always_comb begin
        size = 3'd0;
        sgn  = 1'b0;
        st   = 1'b0;
        case (iMemControl)
            4'b0000: size = 3'd4;
            4'b0001: begin size = 3'd2; sgn = 1'b1; end
            4'b0010: begin size = 3'd1; sgn = 1'b1; end
            4'b0011: size = 3'd2;
            4'b0100: size = 3'd1;
            4'b0101: begin size = 3'd4; st = 1'b1; end
            4'b0110: begin size = 3'd2; st = 1'b1; end
            4'b0111: begin size = 3'd1; st = 1'b1; end
            default: size = 3'd0;
        endcase
        case (size)
            3'd4:    smask = 4'b1111;
            3'd2:    smask = 4'b0011;
            3'd1:    smask = 4'b0001;
            default: smask = 4'b0000;
        endcase
        strad  = ({1'b0, iAddr[1:0]} + size) > 3'd4;
        be_img = 8'({4'b0000, smask} << iAddr[1:0]);
        w_img  = {32'b0, iWriteData} << {iAddr[1:0], 3'b000};
        accept = (state_q == S_IDLE) && iReqValid && (size != 3'd0);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) begin
`ifdef MEM_MISALIGN_SPLIT_EN
                state_d = S_ACC1;
`else
                state_d = strad ? S_RESP : S_ACC1;
`endif
            end
            S_ACC1: if (iRamAck) begin
`ifdef MEM_MISALIGN_SPLIT_EN
                state_d = strad_q ? S_ACC2 : S_RESP;
`else
                state_d = S_RESP;
`endif
            end
`ifdef MEM_MISALIGN_SPLIT_EN
            S_ACC2: if (iRamAck) state_d = S_RESP;
`endif
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_q <= S_IDLE;
            st_q    <= 1'b0;
            sgn_q   <= 1'b0;
            size_q  <= 3'd0;
            off_q   <= 2'd0;
            waddr_q <= '0;
            be_q    <= 8'h00;
            wimg_q  <= 64'h0;
            rd0_q   <= 32'h0;
            rd1_q   <= 32'h0;
`ifdef MEM_MISALIGN_SPLIT_EN
            strad_q <= 1'b0;
`else
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                st_q    <= st;
                sgn_q   <= sgn;
                size_q  <= size;
                off_q   <= iAddr[1:0];
                waddr_q <= iAddr[ADDR_WIDTH-1:2];
                be_q    <= be_img;
                wimg_q  <= w_img;
                rd0_q   <= 32'h0;
                rd1_q   <= 32'h0;
`ifdef MEM_MISALIGN_SPLIT_EN
                strad_q <= strad;
`else
                err_q   <= strad;
`endif
            end
            if (state_q == S_ACC1 && iRamAck) rd0_q <= iRamRData;
`ifdef MEM_MISALIGN_SPLIT_EN
            if (state_q == S_ACC2 && iRamAck) rd1_q <= iRamRData;
`endif
        end
    end

    logic ram_req, second;
    logic [31:0] lo, ext;

    always_comb begin
`ifdef MEM_MISALIGN_SPLIT_EN
        second = (state_q == S_ACC2);
`else
        second = 1'b0;
`endif
        ram_req    = (state_q == S_ACC1) || second;
        oReqReady  = (state_q == S_IDLE);
        oBusy      = (state_q != S_IDLE);
        oRespValid = (state_q == S_RESP);
        // RAM-side outputs are forced to zero outside a transaction
        oRamReq    = ram_req;
        oRamWe     = ram_req & st_q;
        oRamBe     = ram_req ? (second ? be_q[7:4] : be_q[3:0]) : 4'b0000;
        oRamAddr   = ram_req ? (second ? waddr_q + {{(WA-1){1'b0}}, 1'b1} : waddr_q) : '0;
        oRamWData  = ram_req ? (second ? wimg_q[63:32] : wimg_q[31:0]) : 32'h0;

        lo = 32'({rd1_q, rd0_q} >> {off_q, 3'b000});
        case (size_q)
            3'd1:    ext = {{24{sgn_q & lo[7]}}, lo[7:0]};
            3'd2:    ext = {{16{sgn_q & lo[15]}}, lo[15:0]};
            default: ext = lo;
        endcase
`ifdef MEM_MISALIGN_SPLIT_EN
        oRespErr  = 1'b0;
        oRespData = (oRespValid && !st_q) ? ext : 32'h0;
`else
        oRespErr  = oRespValid & err_q;
        oRespData = (oRespValid && !st_q && !err_q) ? ext : 32'h0;
`endif
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit; expectations are pushed at issue and popped on oRespValid.
module tb_mem_access_unit;
    logic        iClk = 1'b0;
    logic        iRstN, iReqValid, iRamAck;
    logic [3:0]  iMemControl;
    logic [31:0] iAddr, iWriteData, iRamRData;
    logic        oReqReady, oBusy, oRespValid, oRespErr, oRamReq, oRamWe;
    logic [31:0] oRespData, oRamWData;
    logic [3:0]  oRamBe;
    logic [29:0] oRamAddr;

    mem_access_unit #(.ADDR_WIDTH(32)) dut (
        .iClk(iClk), .iRstN(iRstN), .iReqValid(iReqValid), .oReqReady(oReqReady),
        .iMemControl(iMemControl), .iAddr(iAddr), .iWriteData(iWriteData), .oBusy(oBusy),
        .oRespValid(oRespValid), .oRespData(oRespData), .oRespErr(oRespErr),
        .oRamReq(oRamReq), .iRamAck(iRamAck), .oRamWe(oRamWe), .oRamBe(oRamBe),
        .oRamAddr(oRamAddr), .oRamWData(oRamWData), .iRamRData(iRamRData)
    );

    always #5 iClk = ~iClk;

    int checks = 0;
    int failures = 0;
    typedef struct { logic [31:0] data; logic err; } resp_t;
    resp_t exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    always @(negedge iClk) begin
        resp_t r;
        if (iRstN === 1'b1) begin
            if (oRamReq !== 1'b1) chk("idle_ram_zero", {oRamWe, oRamBe}, 0);
            if (oRespValid === 1'b1) begin
                if (exp_q.size() == 0) chk("unexpected_resp", 1, 0);
                else begin
                    r = exp_q.pop_front();
                    chk("resp_data", oRespData, r.data);
                    chk("resp_err", oRespErr, r.err);
                end
            end
        end
    end

    task automatic issue(input logic [3:0] code, input logic [31:0] addr, input logic [31:0] wd,
                         input bit push, input logic [31:0] ed, input logic ee);
        resp_t r;
        chk("req_ready", oReqReady, 1);
        iReqValid = 1'b1; iMemControl = code; iAddr = addr; iWriteData = wd;
        if (push) begin r.data = ed; r.err = ee; exp_q.push_back(r); end
        @(negedge iClk);
        iReqValid = 1'b0;
    endtask

    task automatic ram_cycle(input string tag, input logic [29:0] ea, input logic [3:0] ebe,
                             input logic ewe, input logic [31:0] ewd, input logic [31:0] rd,
                             input int waits);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{ebe[b]}};
        for (int i = 0; i < waits; i++) begin
            chk({tag, "_wait_req"}, oRamReq, 1);
            chk({tag, "_wait_addr"}, oRamAddr, ea);
            chk({tag, "_wait_wdata"}, oRamWData & m, ewd);
            chk({tag, "_wait_busy"}, oBusy, 1);
            @(negedge iClk);
        end
        chk({tag, "_req"}, oRamReq, 1);
        chk({tag, "_addr"}, oRamAddr, ea);
        chk({tag, "_be"}, oRamBe, ebe);
        chk({tag, "_we"}, oRamWe, ewe);
        chk({tag, "_wdata"}, oRamWData & m, ewd);
        iRamAck = 1'b1; iRamRData = rd;
        @(negedge iClk);
        iRamAck = 1'b0; iRamRData = 32'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1);
    end

    initial begin
        iRstN = 1'b0; iReqValid = 1'b0; iRamAck = 1'b0;
        iMemControl = 4'b1000; iAddr = '0; iWriteData = '0; iRamRData = '0;
        repeat (2) @(negedge iClk);
        chk("rst_ram_req", oRamReq, 0);
        chk("rst_resp_valid", oRespValid, 0);
        chk("rst_busy", oBusy, 0);
        chk("rst_ram_outs", {oRamWe, oRamBe, oRamAddr, oRamWData}, 0);
        chk("rst_resp_outs", {oRespErr, oRespData}, 0);
        iRstN = 1'b1;
        @(negedge iClk);

        issue(4'b0101, 32'h10, 32'hDEADBEEF, 1, 32'h0, 1'b0);
        ram_cycle("sw", 30'h4, 4'hF, 1'b1, 32'hDEADBEEF, 32'h0, 0);
        chk("sw_t2_valid", oRespValid, 1);
        @(negedge iClk);

        issue(4'b0010, 32'h13, 32'h0, 1, 32'hFFFF_FF80, 1'b0);
        ram_cycle("lb", 30'h4, 4'h8, 1'b0, 32'h0, 32'h80FF_0000, 0);
        chk("lb_t2_valid", oRespValid, 1);
        @(negedge iClk);

        issue(4'b0100, 32'h13, 32'h0, 1, 32'h0000_0080, 1'b0);
        ram_cycle("lbu", 30'h4, 4'h8, 1'b0, 32'h0, 32'h80FF_0000, 0);
        @(negedge iClk);

        issue(4'b0110, 32'h21, 32'h1234, 1, 32'h0, 1'b0);
        ram_cycle("sh", 30'h8, 4'h6, 1'b1, 32'h0012_3400, 32'h0, 0);
        @(negedge iClk);

        issue(4'b0001, 32'h22, 32'h0, 1, 32'hFFFF_8001, 1'b0);
        ram_cycle("lh", 30'h8, 4'hC, 1'b0, 32'h0, 32'h8001_5555, 0);
        @(negedge iClk);

        issue(4'b0011, 32'h22, 32'h0, 1, 32'h0000_8001, 1'b0);
        ram_cycle("lhu", 30'h8, 4'hC, 1'b0, 32'h0, 32'h8001_5555, 0);
        @(negedge iClk);

`ifdef MEM_MISALIGN_SPLIT_EN
        issue(4'b0000, 32'h0F, 32'h0, 1, 32'hDDCC_BBAA, 1'b0);
        ram_cycle("lw_a1", 30'h3, 4'h8, 1'b0, 32'h0, 32'hAA00_0000, 0);
        ram_cycle("lw_a2", 30'h4, 4'h7, 1'b0, 32'h0, 32'h00DD_CCBB, 0);
        chk("lw_t3_valid", oRespValid, 1);
        @(negedge iClk);
        issue(4'b0001, 32'hFFFF_FFFF, 32'h0, 1, 32'h0000_3412, 1'b0);
        ram_cycle("wrap_a1", 30'h3FFF_FFFF, 4'h8, 1'b0, 32'h0, 32'h1200_0000, 0);
        ram_cycle("wrap_a2", 30'h0, 4'h1, 1'b0, 32'h0, 32'h0000_0034, 0);
        @(negedge iClk);
`else
        issue(4'b0000, 32'h0F, 32'h0, 1, 32'h0, 1'b1);
        chk("lw_mis_noreq", oRamReq, 0);
        chk("lw_mis_t1_valid", oRespValid, 1);
        @(negedge iClk);
        issue(4'b0001, 32'hFFFF_FFFF, 32'h0, 1, 32'h0, 1'b1);
        chk("wrap_mis_noreq", oRamReq, 0);
        @(negedge iClk);
`endif

        issue(4'b1000, 32'h40, 32'h0, 0, 32'h0, 1'b0);
        chk("none_busy", oBusy, 0);
        chk("none_ramreq", oRamReq, 0);
        issue(4'b1111, 32'h44, 32'h0, 0, 32'h0, 1'b0);
        chk("none_f_busy", oBusy, 0);

        issue(4'b0111, 32'h5, 32'hAB, 1, 32'h0, 1'b0);
        iReqValid = 1'b1; iMemControl = 4'b0000; iAddr = 32'h100; iWriteData = 32'hFFFF_FFFF;
        ram_cycle("sb_wait", 30'h1, 4'h2, 1'b1, 32'h0000_AB00, 32'h0, 3);
        iReqValid = 1'b0;
        chk("sb_resp_valid", oRespValid, 1);
        @(negedge iClk);

        issue(4'b0111, 32'h9, 32'hCD, 0, 32'h0, 1'b0);
        chk("rst_mid_req_pre", oRamReq, 1);
        #2 iRstN = 1'b0;
        #1 chk("rst_mid_req_drop", oRamReq, 0);
        chk("rst_mid_busy", oBusy, 0);
        @(negedge iClk);
        #1 iRstN = 1'b1;
        repeat (4) @(negedge iClk);
        chk("rst_mid_idle", oBusy, 0);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Consumer of the 4-bit memory-control code produced by control decode; sits between the pipeline memory stage and a word-organised data RAM.
- Accepts one load/store request, generates word address, byte enables and lane-shifted store data, and returns sign- or zero-extended load data.
- Multi-cycle accesses use a valid/ready handshake with the RAM.
- Optionally splits accesses that straddle a word boundary into two RAM transactions.

Parameters:
- ADDR_WIDTH, 32, byte-address width. RAM word address is ADDR_WIDTH-2 bits.

Ports:
- iClk in 1: clock, rising edge.
- iRstN in 1: asynchronous active-low reset.
- iReqValid in 1: request present.
- oReqReady out 1: unit can accept; high only in IDLE.
- iMemControl in 4: 0000 LW, 0001 LH, 0010 LB, 0011 LHU, 0100 LBU, 0101 SW, 0110 SH, 0111 SB, 1000 none. Codes 1001-1111 are treated as none.
- iAddr in ADDR_WIDTH: byte address.
- iWriteData in 32: store data, right-aligned.
- oBusy out 1: state != IDLE; used as pipeline stall.
- oRespValid out 1: one-cycle pulse marking access complete.
- oRespData out 32: extended load data; 0 for stores.
- oRespErr out 1: misaligned access rejected; qualified by oRespValid.
- oRamReq out 1: RAM transaction request.
- iRamAck in 1: RAM accepts/completes the transaction this cycle.
- oRamWe out 1: write transaction.
- oRamBe out 4: byte enables.
- oRamAddr out ADDR_WIDTH-2: word address.
- oRamWData out 32: lane-aligned write data.
- iRamRData in 32: read data, valid in the cycle iRamAck=1.

Behaviour:
- Reset (async, iRstN=0): state=IDLE. oRamReq, oRespValid, oRespErr, oRamWe=0. oRamBe, oRamAddr, oRamWData, oRespData=0. Captured request registers cleared.
- Reset mid-transaction aborts it: no response is issued, and oRamReq drops immediately.
- Accept: in IDLE with iReqValid=1 and code not "none", capture code, address and data; go to ACC1. Requests with code "none" are consumed with no RAM activity and no response.
- Size: 4 for W, 2 for H/HU, 1 for B/BU. offset = iAddr[1:0]. Straddle when offset+size > 4.
- Lane formation:
  - 64-bit store image = iWriteData << (8*offset).
  - 8-bit enable image = sizeMask << offset, where sizeMask = 0001, 0011 or 1111.
  - First transaction uses the low halves; second uses the high halves.
- Addresses: first = iAddr[ADDR_WIDTH-1:2]; second = first+1, wrapping modulo 2^(ADDR_WIDTH-2).
- States:
  - IDLE: oReqReady=1.
  - ACC1: oRamReq=1 with first-word signals held stable until iRamAck. On ack, go to ACC2 if straddling, else RESP.
  - ACC2: oRamReq=1 with second-word signals until ack, then RESP. Read data from ACC1 is held in a register.
  - RESP: oRespValid=1 for exactly one cycle, then IDLE.
- Loads:
  - Form {second, first} words; a non-straddling access uses first only.
  - Shift right by 8*offset and take the low size bytes.
  - LH/LB sign-extend; LHU/LBU zero-extend.
- Stores: oRespData=0.
- Latency, with iRamAck returned in the same cycle as oRamReq:
  - Non-split access: accept T0, RAM cycle T1, oRespValid T2.
  - Split access: oRespValid T3.
- Each extra RAM wait cycle adds one cycle.
- iReqValid is ignored while oBusy=1.
- oRamBe=0 and oRamWe=0 whenever oRamReq=0.

Optional Feature:
- MEM_MISALIGN_SPLIT_EN defined: straddling accesses are split as described; oRespErr is always 0.
- MEM_MISALIGN_SPLIT_EN undefined:
  - Straddling accesses perform no RAM transaction; state goes IDLE -> RESP directly.
  - oRespValid=1 with oRespErr=1 and oRespData=0.
  - ACC2 is not instantiated.

Test Plan:
- Reset, then SW addr 0x0000_0010 data 0xDEADBEEF, immediate ack -> T1 oRamAddr=0x4, oRamBe=1111, oRamWData=0xDEADBEEF, oRamWe=1; T2 oRespValid=1, oRespErr=0.
- LB addr 0x13, RAM returns 0x80FF_0000 -> oRespData=0xFFFF_FF80. Same with LBU -> 0x0000_0080.
- SH addr 0x21 data 0x1234 -> single transaction, oRamAddr=0x8, oRamBe=0110, oRamWData[23:8]=0x1234.
- LW addr 0x0F, with the feature enabled:
  - ACC1: addr 0x3, Be=1000, returns 0xAA00_0000.
  - ACC2: addr 0x4, Be=0111, returns 0x00DD_CCBB.
  - oRespData=0xDDCCBBAA at T3.
- Same LW with the feature disabled -> no oRamReq; oRespValid with oRespErr=1 and data 0 in the cycle after accept.
- SB with iRamAck held low for 3 cycles -> oRamReq and its address/data stay stable; oBusy=1; a new iReqValid is ignored. iRstN pulsed low during the wait -> oRamReq falls immediately; no oRespValid follows.
